// File: rtl/spoc_pkg.sv
// Shared definitions for the SpoC-64 sLiSCP-light-192 permutation blocks:
// sizes, controller state encoding and the per-step constant tables.
package spoc_pkg;

    localparam int SLISCP_WIDTH = 48;
    localparam int SLISCP_STEPS = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } perm_state_e;

    // Ascending index range: the leftmost literal is the step-0 entry.
    localparam logic [0:SLISCP_STEPS-1][7:0] RC0_TAB = {
        8'h07, 8'h04, 8'h06, 8'h25, 8'h17, 8'h1c, 8'h12, 8'h3b, 8'h26,
        8'h15, 8'h3f, 8'h20, 8'h30, 8'h28, 8'h3c, 8'h22, 8'h33, 8'h2a
    };
    localparam logic [0:SLISCP_STEPS-1][7:0] RC1_TAB = {
        8'h27, 8'h34, 8'h2e, 8'h19, 8'h35, 8'h0f, 8'h08, 8'h0c, 8'h0a,
        8'h2f, 8'h38, 8'h24, 8'h36, 8'h1d, 8'h3d, 8'h31, 8'h09, 8'h2d
    };
    localparam logic [0:SLISCP_STEPS-1][7:0] SC0_TAB = {
        8'h08, 8'h0c, 8'h0a, 8'h2f, 8'h38, 8'h24, 8'h36, 8'h1d, 8'h3d,
        8'h31, 8'h09, 8'h2d, 8'h1b, 8'h3e, 8'h0b, 8'h12, 8'h13, 8'h34
    };
    localparam logic [0:SLISCP_STEPS-1][7:0] SC1_TAB = {
        8'h29, 8'h1d, 8'h1f, 8'h21, 8'h2b, 8'h3d, 8'h37, 8'h33, 8'h3b,
        8'h29, 8'h19, 8'h01, 8'h0d, 8'h0b, 8'h23, 8'h3c, 8'h2a, 8'h11
    };

endpackage

// File: rtl/sliscp_const_rom.sv
// Step index -> round/step constants for sLiSCP-light-192. Purely
// combinational so it can be replicated by an unrolled permutation.
module sliscp_const_rom
    import spoc_pkg::*;
#(
    parameter int STEP_CW = 5
) (
    input  logic [STEP_CW-1:0] step_i,
    output logic [7:0]         rc0_o,
    output logic [7:0]         rc1_o,
    output logic [7:0]         sc0_o,
    output logic [7:0]         sc1_o
);

    always_comb begin
        rc0_o = '0;
        rc1_o = '0;
        sc0_o = '0;
        sc1_o = '0;
        // Indices past the table are unreachable from the controller.
        if (int'(step_i) < SLISCP_STEPS) begin
            rc0_o = RC0_TAB[step_i];
            rc1_o = RC1_TAB[step_i];
            sc0_o = SC0_TAB[step_i];
            sc1_o = SC1_TAB[step_i];
        end
    end

endmodule

// File: rtl/sliscp_perm_ctrl.sv
// Iterating controller and state register for the sLiSCP-light permutation:
// feeds the step datapath, captures each step result, pulses done at the end.
module sliscp_perm_ctrl
    import spoc_pkg::*;
#(
    parameter int WIDTH     = SLISCP_WIDTH,
    parameter int NUM_STEPS = SLISCP_STEPS,
    parameter int STEP_CW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*WIDTH-1:0]   din,
    output logic                 busy,
    output logic                 done,
    output logic [4*WIDTH-1:0]   dout,
    output logic [4*WIDTH-1:0]   step_sin,
    input  logic [4*WIDTH-1:0]   step_sout,
    input  logic                 rnd_done,
    output logic                 en_rnd_ctr,
    output logic [7:0]           rc0,
    output logic [7:0]           rc1,
    output logic [7:0]           sc0,
    output logic [7:0]           sc1
);

    localparam logic [STEP_CW-1:0] LAST_STEP = STEP_CW'(NUM_STEPS - 1);

    perm_state_e          state_q;
    logic [STEP_CW-1:0]   step_q;
    logic [4*WIDTH-1:0]   data_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 en_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        data_q  <= din;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        en_q    <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rnd_done) begin
                        data_q <= step_sout;
                        if (step_q == LAST_STEP) begin
                            busy_q  <= 1'b0;
                            en_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            // Next step begins immediately on the new state.
                            step_q <= step_q + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    step_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    en_q    <= 1'b0;
                    done_q  <= 1'b0;
                    step_q  <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sliscp_const_rom #(
        .STEP_CW (STEP_CW)
    ) u_const_rom (
        .step_i (step_q),
        .rc0_o  (rc0),
        .rc1_o  (rc1),
        .sc0_o  (sc0),
        .sc1_o  (sc1)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign en_rnd_ctr = en_q;
    assign dout       = data_q;
    assign step_sin   = data_q;

endmodule

// File: doc/sliscp_perm_ctrl.md
Name: sliscp_perm_ctrl

Overview:
- Iterating controller and state register for the SpoC-64 sLiSCP-light permutation; sits directly upstream of the per-step datapath (SLiSCP_step) and also consumes its output.
- Loads a 4*WIDTH-bit state on a start handshake and drives it into the step datapath.
- Supplies the per-step round/step constants and captures the step result on each rnd_done.
- After NUM_STEPS steps, presents the permuted state with a one-cycle done pulse.

Parameters:
- WIDTH, 48, sub-block width; state is 4*WIDTH bits.
- NUM_STEPS, 18, permutation steps per invocation.
- STEP_CW, 5, width of step counter; must satisfy 2^STEP_CW > NUM_STEPS.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request permutation of din; honoured only in IDLE.
- din  in  4*WIDTH  input state, sampled in the cycle start is accepted.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; dout valid from this cycle on.
- dout  out  4*WIDTH  permuted state; holds until next accepted start.
- step_sin  out  4*WIDTH  current state to step datapath (= state register).
- step_sout  in  4*WIDTH  step datapath result.
- rnd_done  in  1  step datapath finished current step; step_sout valid this cycle.
- en_rnd_ctr  out  1  enables the step datapath round counter.
- rc0, rc1, sc0, sc1  out  8 each  step constants for current step index.

Behaviour:
- Reset (rst=0 at edge): FSM=IDLE, step counter=0, state register=0, busy=0, done=0, en_rnd_ctr=0. Constants are the step-0 values. Reset mid-RUN aborts with no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - If start=1: load state<=din, step<=0, go to RUN.
  - busy=0, en_rnd_ctr=0.
- RUN:
  - busy=1, en_rnd_ctr=1.
  - step_sin=state, held stable for the whole step.
  - On rnd_done=1: state<=step_sout.
    - If step==NUM_STEPS-1: go to FIN.
    - Else step<=step+1 and remain in RUN. The next step starts next cycle with no bubble.
  - rnd_done outside RUN is ignored.
- FIN:
  - done=1 for exactly one cycle, busy=0, en_rnd_ctr=0, step<=0.
  - Return to IDLE. start in FIN is ignored.
- dout = state register. It is updated only by captures, so it is stable from done until the next acceptance.
- Constants are combinational lookups on step:
  - rc0=RC0_TAB[step], rc1=RC1_TAB[step], sc0=SC0_TAB[step], sc1=SC1_TAB[step].
  - Values change only when the step counter changes, i.e. the cycle after a capture.
- Latency with a datapath taking R cycles per step, start accepted at cycle 0:
  - First capture at cycle R.
  - done at cycle NUM_STEPS*R+1 (R=6: cycle 109).
- The step counter never exceeds NUM_STEPS-1; no wrap-around occurs in RUN.
- start held high continuously: exactly one acceptance per IDLE visit; the next acceptance is in the cycle after FIN.

Decomposition:
- Shared package spoc_pkg:
  - SLISCP_WIDTH=48 and SLISCP_STEPS=18.
  - FSM state enum.
  - The four 18-entry 8-bit constant tables RC0_TAB, RC1_TAB, SC0_TAB, SC1_TAB (sLiSCP-light-192 values).
- One natural sub-module: sliscp_const_rom (step index -> rc0/rc1/sc0/sc1), shared with any future unrolled variant.

Test Plan:
- Basic run: reset, start with din=192'h0, bench step model = identity with rnd_done after 6 cycles -> done at cycle 109 after acceptance, dout=0, exactly 18 rnd_done captures.
- Data path: step model = increment of s3 field, din=0 -> dout low 48 bits = 18, upper 144 bits = 0; busy high cycles 1..108.
- Constants: log rc0/rc1/sc0/sc1 at each capture -> sequence equals RC0_TAB[0..17] etc.; step-0 values visible in the cycle after acceptance.
- Handshake: start held high across two runs, plus spurious start at cycles 50 and 109 -> exactly two acceptances, second in the cycle after done; din change mid-run does not affect dout.
- Reset mid-operation: drive rst=0 at cycle 40 -> next cycle busy=0, done never pulses, dout=0, en_rnd_ctr=0; a new start then completes normally.
- Variable step timing: rnd_done after 1 cycle (back-to-back) -> done at cycle 19, no missed or duplicated capture; spurious rnd_done in IDLE -> ignored.
